ram_accum_reader: RTL

- Initiator-side controller for the 64 x 512-bit synchronous RAM (registered read address, one-cycle read latency, synchronous write).
- On a start pulse it reads a run of consecutive words and adds them lane-wise: 16 lanes x 32 bits by default.
- It then writes the lane-wise sum back to a destination word and reports completion.
- It sits between the top-level accumulator control and the RAM port, and is the sole driver of that port while busy.

---
 rtl/ram_accum_reader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ram_accum_reader.sv
// Initiator-side controller for the 64 x 512-bit RAM. It reads a run of consecutive
// words, adds them lane by lane, and writes the sum back to a destination word.
module ram_accum_reader #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 6,
  parameter int LANE_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int LANES = DATA_W / LANE_W;

  typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic                first_q, first_d;
  logic                zero_q, zero_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   sum_s;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  // Independent modular add per lane; carries never cross a lane boundary.
  function automatic logic [DATA_W-1:0] lane_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int k = 0; k < LANES; k++) begin
      s[k*LANE_W +: LANE_W] = a[k*LANE_W +: LANE_W] + b[k*LANE_W +: LANE_W];
    end
    return s;
  endfunction

  assign sum_s = lane_add(acc_q, ram_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A zero-length run lingers one extra cycle in DONE so done lands two cycles after start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (count == (ADDR_W+1)'(0)) ? DONE : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (remain_q == (ADDR_W+1)'(0)) begin
          state_d = LAST;
        end else begin
          state_d = READ;
        end
      end
      LAST:    state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = zero_q ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    remain_d    = remain_q;
    dst_d       = dst_q;
    first_d     = first_q;
    zero_d      = zero_q;
    acc_d       = acc_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    result_d    = result_q;
    ram_addr_d  = '0;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == (ADDR_W+1)'(0)) begin
            zero_d   = 1'b1;
            result_d = '0;
          end else begin
            acc_d      = '0;
            dst_d      = dst_addr;
            remain_d   = count - (ADDR_W+1)'(1);
            first_d    = 1'b1;
            ram_addr_d = src_addr;
            busy_d     = 1'b1;
          end
        end else begin
          zero_d = 1'b0;
        end
      end
      READ: begin
        busy_d  = 1'b1;
        first_d = 1'b0;
        if (!first_q) begin
          acc_d = sum_s;
        end else begin
          acc_d = acc_q;
        end
        if (remain_q != (ADDR_W+1)'(0)) begin
          ram_addr_d = ram_addr_q + ADDR_W'(1);
          remain_d   = remain_q - (ADDR_W+1)'(1);
        end else begin
          ram_addr_d = ram_addr_q;
        end
      end
      LAST: begin
        acc_d       = sum_s;
        busy_d      = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = dst_q;
        ram_wdata_d = sum_s;
      end
      WRITE: begin
        result_d = acc_q;
        done_d   = 1'b1;
      end
      DONE: begin
        if (zero_q) begin
          zero_d = 1'b0;
          done_d = 1'b1;
        end else begin
          zero_d = 1'b0;
        end
      end
      default: begin
        zero_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remain_q    <= '0;
      dst_q       <= '0;
      first_q     <= 1'b0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      remain_q    <= remain_d;
      dst_q       <= dst_d;
      first_q     <= first_d;
      zero_q      <= zero_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule
